// File: rtl/shadow_registers_pkg.sv
// registers_pkg: shared constants and helper functions for the shadow register file.
//   RD_LATENCY     - cycles from a sampled read request to valid data_out.
//   MAX_DATA_WIDTH - widest register the byte_merge helper supports.
//   num_lanes()    - byte-lane count for a given register width.
//   byte_merge()   - lane-wise merge of new data into an old word under a byte enable.
package registers_pkg;

    localparam int RD_LATENCY     = 1;
    localparam int MAX_DATA_WIDTH = 256;
    localparam int MAX_LANES      = MAX_DATA_WIDTH / 8;

    function automatic int num_lanes(input int data_width);
        return data_width / 8;
    endfunction

    // Callers zero-extend their words to MAX_DATA_WIDTH and truncate the result back.
    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_LANES-1:0]      be
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/shadow_registers_if.sv
// shadow_registers_if: host access bus of the shadow register file.
//   en, rd, wr    - access enable and read/write requests (master -> slave)
//   be            - byte-lane enables, bit i covers data bits [8i+7:8i]
//   addr, data_in - word address and write data
//   data_out      - registered read data (slave -> master)
//   rd_valid      - one-cycle pulse, data_out has just been updated
interface shadow_registers_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                    en;
    logic                    rd;
    logic                    wr;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data_in;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    rd_valid;

    modport master (
        output en, rd, wr, be, addr, data_in,
        input  data_out, rd_valid
    );

    modport slave (
        input  en, rd, wr, be, addr, data_in,
        output data_out, rd_valid
    );
endinterface

// File: rtl/shadow_registers_word.sv
// register_word: one register of the shadow register file.
//   clk, reset - clock and asynchronous active-low reset
//   wr_hit     - a performed host write targets this register
//   be         - byte-lane enables of the write
//   data_in    - write data
//   commit     - copy shadow to active (double-buffered registers only)
//   shadow     - host-visible shadow word
//   active     - core-facing word; the shadow word itself when DB = 0
module register_word
    import registers_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 16,
    parameter bit                    DB          = 1'b1,
    parameter bit                    RO          = 1'b0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_hit,
    input  logic [num_lanes(DATA_WIDTH)-1:0] be,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic                             commit,
    output logic [DATA_WIDTH-1:0]            shadow,
    output logic [DATA_WIDTH-1:0]            active
);

    logic [DATA_WIDTH-1:0] shadow_r;
    logic [DATA_WIDTH-1:0] active_r;
    logic [DATA_WIDTH-1:0] merged_s;
    logic [DATA_WIDTH-1:0] shadow_next_s;

    // Next shadow value; a commit in the same cycle as a write must see the written data.
    always_comb begin
        merged_s = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(shadow_r),
                                          MAX_DATA_WIDTH'(data_in),
                                          MAX_LANES'(be)));
        if (wr_hit && !RO) begin
            shadow_next_s = merged_s;
        end else begin
            shadow_next_s = shadow_r;
        end
    end

    // Shadow and active storage; for RO registers both stay at RESET_VALUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_r <= RESET_VALUE;
            active_r <= RESET_VALUE;
        end else begin
            shadow_r <= shadow_next_s;
            if (commit) begin
                active_r <= shadow_next_s;
            end
        end
    end

    assign shadow = shadow_r;
    assign active = DB ? active_r : shadow_r;

endmodule

// File: rtl/shadow_registers.sv
// shadow_registers: parametrised double-buffered register file for the host bus.
//   clk, reset - clock and asynchronous active-low reset
//   bus        - host access bus (shadow_registers_if.slave)
//   commit     - copy shadow to active for all double-buffered registers
//   dirty      - a double-buffered register holds an uncommitted write
//   active     - core-facing register values, register r at [r*DATA_WIDTH +: DATA_WIDTH]
module shadow_registers
    import registers_pkg::*;
#(
    parameter int                               ADDR_WIDTH   = 8,
    parameter int                               DATA_WIDTH   = 16,
    parameter int                               NUM_REGS     = 16,
    parameter logic [NUM_REGS-1:0]              DB_MASK      = '1,
    parameter logic [NUM_REGS-1:0]              RO_MASK      = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VALUES = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    shadow_registers_if.slave              bus,
    input  logic                           commit,
    output logic                           dirty,
    output logic [NUM_REGS*DATA_WIDTH-1:0] active
);

    logic                  wr_req_s;
    logic                  rd_req_s;
    logic [NUM_REGS-1:0]   wr_hit_s;
    logic                  dirty_set_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic [DATA_WIDTH-1:0] shadow_s [NUM_REGS];
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  rd_valid_r;
    logic                  dirty_r;

    // A write with no enabled lane changes nothing, so it is not a write at all.
    assign wr_req_s = bus.en && bus.wr && (bus.be != '0);
    // A simultaneous write wins over a read.
    assign rd_req_s = bus.en && bus.rd && !bus.wr;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        // Out-of-range addresses match no register and are dropped here.
        assign wr_hit_s[r] = wr_req_s && (bus.addr == ADDR_WIDTH'(r)) && !RO_MASK[r];

        register_word #(
            .DATA_WIDTH  (DATA_WIDTH),
            .DB          (DB_MASK[r]),
            .RO          (RO_MASK[r]),
            .RESET_VALUE (RESET_VALUES[r*DATA_WIDTH +: DATA_WIDTH])
        ) u_word (
            .clk     (clk),
            .reset   (reset),
            .wr_hit  (wr_hit_s[r]),
            .be      (bus.be),
            .data_in (bus.data_in),
            .commit  (commit),
            .shadow  (shadow_s[r]),
            .active  (active[r*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign dirty_set_s = |(wr_hit_s & DB_MASK);

    // Read mux as an AND-OR of one-hot address matches; unmatched addresses read 0.
    always_comb begin
        rd_data_s = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            rd_data_s = rd_data_s | ({DATA_WIDTH{bus.addr == ADDR_WIDTH'(r)}} & shadow_s[r]);
        end
    end

    // Registered read data and its valid pulse; data_out holds between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_r <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_req_s;
            if (rd_req_s) begin
                data_out_r <= rd_data_s;
            end
        end
    end

    // Dirty flag; commit has priority since the committed value already includes the write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dirty_r <= 1'b0;
        end else if (commit) begin
            dirty_r <= 1'b0;
        end else if (dirty_set_s) begin
            dirty_r <= 1'b1;
        end
    end

    assign bus.data_out = data_out_r;
    assign bus.rd_valid = rd_valid_r;
    assign dirty        = dirty_r;

endmodule

// File: tb/tb_shadow_registers.sv
// tb_shadow_registers: self-checking bench for shadow_registers.
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model of the register file kept in plain arrays.
module tb_shadow_registers;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NR = 16;
    localparam logic [NR-1:0]    DB = 16'hffbf;   // r6 immediate
    localparam logic [NR-1:0]    RO = 16'h0020;   // r5 read-only
    localparam logic [NR*DW-1:0] RV = {
        16'h00ff, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0700, 16'h0000, 16'h5a5a, 16'h0000, 16'hcafe, 16'hbeef, 16'h0000, 16'h1234
    };

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            commit = 1'b0;
    logic            dirty;
    logic [NR*DW-1:0] active;

    shadow_registers_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    shadow_registers #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .NUM_REGS     (NR),
        .DB_MASK      (DB),
        .RO_MASK      (RO),
        .RESET_VALUES (RV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .commit (commit),
        .dirty  (dirty),
        .active (active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] sh_m  [NR];
    logic [DW-1:0] act_m [NR];
    logic [DW-1:0] dout_m;
    logic          rv_m;
    logic          dirty_m;
    logic [NR-1:0]    db_v = DB;
    logic [NR-1:0]    ro_v = RO;
    logic [NR*DW-1:0] rv_v = RV;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            sh_m[r]  = rv_v[r*DW +: DW];
            act_m[r] = rv_v[r*DW +: DW];
        end
        dout_m  = '0;
        rv_m    = 1'b0;
        dirty_m = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic rd, input logic wr, input logic [1:0] be,
                              input logic [7:0] addr, input logic [15:0] din, input logic cm);
        int  idx;
        bit  done;
        idx  = int'(addr);
        done = en && wr && (idx < NR) && (be != 2'b00) && !ro_v[idx % NR];
        if (en && rd && !wr) begin
            dout_m = (idx < NR) ? sh_m[idx] : 16'h0000;
            rv_m   = 1'b1;
        end else begin
            rv_m = 1'b0;
        end
        if (done) begin
            for (int l = 0; l < 2; l++) begin
                if (be[l]) sh_m[idx][8*l +: 8] = din[8*l +: 8];
            end
            if (db_v[idx]) dirty_m = 1'b1;
        end
        if (cm) begin
            for (int r = 0; r < NR; r++) begin
                if (db_v[r]) act_m[r] = sh_m[r];
            end
            dirty_m = 1'b0;
        end
        for (int r = 0; r < NR; r++) begin
            if (!db_v[r]) act_m[r] = sh_m[r];
        end
    endtask

    task automatic compare_all();
        logic [NR*DW-1:0] exp_flat;
        for (int r = 0; r < NR; r++) exp_flat[r*DW +: DW] = act_m[r];
        check("data_out", bus.data_out, dout_m);
        check("rd_valid", bus.rd_valid, rv_m);
        check("dirty",    dirty,        dirty_m);
        check("active",   active,       exp_flat);
    endtask

    task automatic cycle(input logic en, input logic rd, input logic wr, input logic [1:0] be,
                         input logic [7:0] addr, input logic [15:0] din, input logic cm);
        bus.en      = en;
        bus.rd      = rd;
        bus.wr      = wr;
        bus.be      = be;
        bus.addr    = addr;
        bus.data_in = din;
        commit      = cm;
        @(posedge clk);
        model_step(en, rd, wr, be, addr, din, cm);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic rd_cycle(input logic [7:0] addr);
        cycle(1'b1, 1'b1, 1'b0, 2'b00, addr, 16'h0000, 1'b0);
    endtask

    task automatic wr_cycle(input logic [7:0] addr, input logic [1:0] be, input logic [15:0] din);
        cycle(1'b1, 1'b0, 1'b1, be, addr, din, 1'b0);
    endtask

    task automatic idle_cycle(input logic cm);
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 16'h0000, cm);
    endtask

    // Drop reset between clock edges and check outputs before any edge arrives.
    task automatic async_reset();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_dirty", dirty, 1'b0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bus.en = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
        bus.be = 2'b00; bus.addr = 8'd0; bus.data_in = 16'h0000;
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_active", active, RV);
        @(negedge clk);
        reset = 1'b1;

        // Reset defaults, back-to-back reads
        rd_cycle(8'd0);  check("rd_r0", bus.data_out, 16'h1234);
        rd_cycle(8'd1);  check("rd_r1", bus.data_out, 16'h0000);
        rd_cycle(8'd2);  check("rd_r2", bus.data_out, 16'hbeef);
        idle_cycle(1'b0); check("rv_drop", bus.rd_valid, 1'b0);

        // Word write, read back, commit
        wr_cycle(8'd0, 2'b11, 16'hdead);
        rd_cycle(8'd0);
        check("wr_r0", bus.data_out, 16'hdead);
        check("act_r0_old", active[0 +: DW], 16'h1234);
        check("dirty_set", dirty, 1'b1);
        idle_cycle(1'b1);
        check("act_r0_new", active[0 +: DW], 16'hdead);
        check("dirty_clr", dirty, 1'b0);

        // Byte lanes on r3 (reset value cafe)
        wr_cycle(8'd3, 2'b10, 16'hffff); rd_cycle(8'd3); check("lane_hi", bus.data_out, 16'hfffe);
        wr_cycle(8'd3, 2'b01, 16'h0000); rd_cycle(8'd3); check("lane_lo", bus.data_out, 16'hff00);
        wr_cycle(8'd3, 2'b00, 16'h1234); rd_cycle(8'd3); check("lane_none", bus.data_out, 16'hff00);
        idle_cycle(1'b1);

        // Read-only and immediate registers
        wr_cycle(8'd5, 2'b11, 16'h5555); rd_cycle(8'd5); check("ro_r5", bus.data_out, 16'h5a5a);
        check("ro_dirty", dirty, 1'b0);
        wr_cycle(8'd6, 2'b11, 16'h6666);
        check("imm_r6", active[6*DW +: DW], 16'h6666);
        check("imm_dirty", dirty, 1'b0);

        // Write, read and commit together; out-of-range read
        cycle(1'b1, 1'b1, 1'b1, 2'b11, 8'd1, 16'hface, 1'b1);
        check("col_rv", bus.rd_valid, 1'b0);
        check("col_act", active[1*DW +: DW], 16'hface);
        check("col_dirty", dirty, 1'b0);
        rd_cycle(8'd200);
        check("oor_data", bus.data_out, 16'h0000);
        check("oor_rv", bus.rd_valid, 1'b1);
        wr_cycle(8'd200, 2'b11, 16'h9999);
        check("oor_dirty", dirty, 1'b0);

        // Async reset with uncommitted writes pending
        wr_cycle(8'd2, 2'b11, 16'h1111);
        wr_cycle(8'd4, 2'b11, 16'h2222);
        bus.wr = 1'b1;
        async_reset();
        rd_cycle(8'd2); check("rst_r2", bus.data_out, 16'hbeef);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
            cycle(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                  2'($urandom), a, 16'($urandom), 1'($urandom_range(0, 5) == 0));
            if (i == 400) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/shadow_registers.md
# shadow_registers

- Parametrised, double-buffered register file for the ChronoCube host bus.
- Host writes land in a shadow copy. Registers flagged as double-buffered only reach the core-facing outputs on a `commit` strobe, normally the frame/vblank boundary, so a multi-word update appears atomically.
- Compared with the existing register block, it adds generic width and depth, N byte lanes, per-register reset values, read-only and immediate-update registers, and a registered read with a valid flag.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, word-address width.
- `DATA_WIDTH`, 16, register width; must be a multiple of 8.
- `NUM_REGS`, 16, number of implemented registers; must be ≤ 2^ADDR_WIDTH.
- `DB_MASK`, all ones (NUM_REGS bits), bit r = 1 makes register r double-buffered; 0 makes it immediate.
- `RO_MASK`, 0 (NUM_REGS bits), bit r = 1 makes register r read-only to the host.
- `RESET_VALUES`, 0 (NUM_REGS*DATA_WIDTH bits), reset value of register r at bits [r*DATA_WIDTH +: DATA_WIDTH].

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  access enable.
- `rd`  in  1  read request, qualified by `en`.
- `wr`  in  1  write request, qualified by `en`.
- `be`  in  DATA_WIDTH/8  byte-lane enables; bit i covers data bits [8i+7:8i].
- `addr`  in  ADDR_WIDTH  word address.
- `data_in`  in  DATA_WIDTH  write data.
- `data_out`  out  DATA_WIDTH  registered read data.
- `rd_valid`  out  1  one-cycle pulse: `data_out` has just been updated.
- `commit`  in  1  copy shadow to active for all double-buffered registers.
- `dirty`  out  1  at least one double-buffered register has an uncommitted write.
- `active`  out  NUM_REGS*DATA_WIDTH  core-facing register values, flattened.

## Operation
- Storage:
  - Every register has a shadow word.
  - Double-buffered registers also have an active word.
  - For immediate registers, `active` is the shadow word itself.
- Write: on a clock edge with `en & wr`, `addr < NUM_REGS` and `RO_MASK[addr] == 0`, shadow byte lane i takes `data_in` lane i for every i with `be[i]`; other lanes hold.
  - The access is level-sampled: a `wr` held for k cycles writes k times, which is harmless.
- Ignored writes (no state change, no error): out-of-range address, read-only register, or `be == 0`.
- Read: on a clock edge with `en & rd & ~wr`:
  - `data_out` takes the shadow value of `addr`, or 0 if `addr >= NUM_REGS`.
  - `rd_valid` pulses for one cycle.
  - `data_out` then holds until the next read.
  - Reads ignore `be`.
- `rd & wr` in the same cycle: the write is performed, no read occurs, and `rd_valid` stays 0.
- Commit: on a clock edge with `commit`, every double-buffered active word takes its shadow value, and `dirty` clears.
- Write and commit in the same cycle: the committed value includes that write, and `dirty` ends at 0.
- `dirty` is set by any performed write to a double-buffered register. Writes to immediate or ignored registers leave it unchanged.
- Read-only registers keep `RESET_VALUES` permanently; a commit copies that same value to active.

## Timing
- Reset (`reset` low, asynchronous):
  - shadow and active take `RESET_VALUES`;
  - `data_out` = 0, `rd_valid` = 0, `dirty` = 0.
  - Deassertion is synchronised externally.
- Reset asserted mid-access or mid-commit: the access or commit is aborted, with no partial lane update.
- Read latency: 1 cycle. A request sampled at edge n gives valid `data_out` and `rd_valid` = 1 after edge n and until edge n+1.
- Back-to-back reads, one per cycle, are supported; `rd_valid` stays high continuously.
- Write visibility:
  - A read issued in the cycle after a write returns the new value.
  - An immediate register's `active` changes at the write edge.
  - A double-buffered register's `active` changes at the commit edge.
- Commit takes effect in one cycle. A commit held high for k cycles re-copies every cycle.

## Structure
- Package `registers_pkg`:
  - lane-count function `num_lanes(DATA_WIDTH)`;
  - helper function `byte_merge(old, new, be)`;
  - constant `RD_LATENCY = 1`.
- Sub-module `register_word` (instanced NUM_REGS times via generate), with parameters DB, RO and RESET_VALUE:
  - holds the shadow and optional active word;
  - takes `wr_hit`, `be`, `data_in` and `commit`;
  - outputs `shadow` and `active`.
- The top level handles address decode, the read mux, `data_out`/`rd_valid`, and the `dirty` OR-reduction.

## Test plan
- Reset defaults, with RESET_VALUES r0 = `h1234`, r1 = `h0000`, r2 = `hbeef`:
  - read r0, r1, r2 → `h1234`, `h0000`, `hbeef`, each with a 1-cycle `rd_valid` pulse;
  - `dirty` = 0 and `active` equals RESET_VALUES.
- Word write then read:
  - write r0 = `hdead` with `be` = 2'b11;
  - the next-cycle read returns `hdead`;
  - `active` r0 still reads `h1234` and `dirty` = 1;
  - after `commit` pulses, `active` r0 = `hdead` and `dirty` = 0.
- Byte lanes:
  - r3 = `hcafe`; write `hffff` with `be` = 2'b10 → r3 = `hfffe`;
  - write `h0000` with `be` = 2'b01 → r3 = `hff00`;
  - write with `be` = 0 → unchanged.
- Masks, with RO_MASK bit 5 set and DB_MASK bit 6 clear:
  - write r5 = `h5555` → read r5 returns its reset value;
  - write r6 = `h6666` → `active` r6 = `h6666` on the write edge and `dirty` stays 0.
- Collisions:
  - `wr`, `rd` and `commit` high together on r1 with `hface` → `rd_valid` = 0, `active` r1 = `hface` at that edge, `dirty` = 0;
  - read of `addr` = 200 → `data_out` = 0 with `rd_valid` = 1.
- Async reset mid-sequence:
  - after dirty writes, drop `reset` between clock edges → outputs return to reset values immediately, without waiting for an edge.
